// File: rtl/stereo_frame_feeder.sv
// Stereo frame FIFO feeding serial_audio_encoder one word at a time, left then right.
// Output is held off until start_level frames are buffered, so playback does not stutter.
module stereo_frame_feeder #(
   parameter int data_width  = 32,
   parameter int fifo_depth  = 8,
   parameter int start_level = 4
) (
   input  logic                        sclk,
   input  logic                        reset,
   input  logic                        i_valid,
   output logic                        i_ready,
   input  logic [data_width-1:0]       i_left,
   input  logic [data_width-1:0]       i_right,
   output logic                        o_valid,
   input  logic                        o_ready,
   output logic                        o_is_left,
   output logic [data_width-1:0]       o_data,
   output logic [$clog2(fifo_depth):0] o_level,
   output logic                        o_running,
   output logic [15:0]                 o_underflow_count
);

   localparam int aw = $clog2(fifo_depth);
   localparam int lw = aw + 1;

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

   state_t                  state;
   logic [2*data_width-1:0] mem [fifo_depth];
   logic [aw-1:0]           wr_ptr;
   logic [aw-1:0]           rd_ptr;
   logic                    push;
   logic                    pop;
   logic [lw-1:0]           level_next;

   // Ready comes only from the stored level: a same-cycle pop never frees a slot.
   assign i_ready    = (o_level != lw'(fifo_depth));
   assign push       = i_valid && i_ready;
   assign pop        = (state == RIGHT) && o_ready;
   assign level_next = o_level + lw'(push) - lw'(pop);
   assign o_running  = (state != IDLE);

   always_ff @(posedge sclk) begin
      if (push)
         mem[wr_ptr] <= {i_left, i_right};
   end

   always_ff @(posedge sclk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_level <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         o_level <= level_next;
      end
   end

   always_ff @(posedge sclk) begin
      if (reset) begin
         state             <= IDLE;
         o_valid           <= 1'b0;
         o_is_left         <= 1'b1;
         o_underflow_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (o_level >= lw'(start_level)) begin
                  state     <= LEFT;
                  o_valid   <= 1'b1;
                  o_is_left <= 1'b1;
               end
            end
            LEFT: begin
               if (o_ready) begin
                  state     <= RIGHT;
                  o_is_left <= 1'b0;
               end
            end
            RIGHT: begin
               if (o_ready) begin
                  o_is_left <= 1'b1;
                  // A push landing on the final pop keeps the stream alive.
                  if (level_next == '0) begin
                     state   <= IDLE;
                     o_valid <= 1'b0;
                     if (o_underflow_count != 16'hFFFF)
                        o_underflow_count <= o_underflow_count + 16'd1;
                  end else begin
                     state <= LEFT;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               o_valid   <= 1'b0;
               o_is_left <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      o_data = '0;
      case (state)
         LEFT:    o_data = mem[rd_ptr][2*data_width-1:data_width];
         RIGHT:   o_data = mem[rd_ptr][data_width-1:0];
         default: o_data = '0;
      endcase
   end

endmodule

// File: tb/tb_stereo_frame_feeder.sv
// Randomized bench for stereo_frame_feeder against a queue-based model of the frame stream.
module tb_stereo_frame_feeder;

   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int START = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          sclk = 1'b0;
   logic          reset = 1'b1;
   logic          i_valid = 1'b0;
   logic          i_ready;
   logic [DW-1:0] i_left = '0;
   logic [DW-1:0] i_right = '0;
   logic          o_valid;
   logic          o_ready = 1'b0;
   logic          o_is_left;
   logic [DW-1:0] o_data;
   logic [LW-1:0] o_level;
   logic          o_running;
   logic [15:0]   o_underflow_count;

   always #5 sclk = ~sclk;

   stereo_frame_feeder #(.data_width(DW), .fifo_depth(DEPTH), .start_level(START)) dut (
      .sclk(sclk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
      .i_left(i_left), .i_right(i_right), .o_valid(o_valid), .o_ready(o_ready),
      .o_is_left(o_is_left), .o_data(o_data), .o_level(o_level),
      .o_running(o_running), .o_underflow_count(o_underflow_count)
   );

   // Model: frames waiting (head included until its right word is taken),
   // whether the stream is playing, and whether the head's left word is gone.
   logic [2*DW-1:0] q[$];
   bit              playing = 0;
   bit              on_right = 0;
   int              uf = 0;
   bit              chk_en = 0;
   int              n_tests = 0;
   int              n_fail = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [DW-1:0] exp_data;
      exp_data = '0;
      if (playing)
         exp_data = on_right ? q[0][DW-1:0] : q[0][2*DW-1:DW];
      check_val("i_ready",   64'(i_ready),   64'(q.size() != DEPTH));
      check_val("o_valid",   64'(o_valid),   64'(playing));
      check_val("o_is_left", 64'(o_is_left), 64'(!(playing && on_right)));
      check_val("o_data",    64'(o_data),    64'(exp_data));
      check_val("o_level",   64'(o_level),   64'(q.size()));
      check_val("o_running", 64'(o_running), 64'(playing));
      check_val("underflow", 64'(o_underflow_count), 64'(uf));
   endtask

   task automatic step(input bit v, input bit r, input bit rst);
      bit push, fire, start;
      @(negedge sclk);
      if (chk_en) check_outputs();
      i_valid = v;
      o_ready = r;
      reset   = rst;
      i_left  = $urandom;
      i_right = $urandom;
      push  = v && (q.size() != DEPTH);
      fire  = playing && r;
      start = !playing && (q.size() >= START);
      @(posedge sclk);
      if (rst) begin
         q.delete();
         playing  = 0;
         on_right = 0;
         uf       = 0;
      end else begin
         if (push) q.push_back({i_left, i_right});
         if (start) begin
            playing  = 1;
            on_right = 0;
         end else if (fire && !on_right) begin
            on_right = 1;
         end else if (fire) begin
            void'(q.pop_front());
            on_right = 0;
            if (q.size() == 0) begin
               playing = 0;
               if (uf < 65535) uf++;
            end
         end
      end
   endtask

   initial begin
      step(0, 0, 1);
      chk_en = 1;
      step(0, 0, 1);
      // Prefill: three frames must not start output, the fourth must.
      repeat (3) step(1, 0, 0);
      repeat (3) step(0, 0, 0);
      step(1, 0, 0);
      repeat (12) step(0, 1, 0);
      // General random traffic.
      repeat (300) step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, 0);
      // Encoder-like ready: one cycle in 32.
      for (int c = 0; c < 400; c++) step($urandom_range(0, 99) < 8, (c % 32) == 31, 0);
      // Fill past capacity, then drain to empty.
      repeat (12) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      step(1, 0, 0);
      repeat (30) step(0, 1, 0);
      // Refill below the start level, then reach it.
      repeat (3) step(1, 1, 0);
      repeat (3) step(0, 1, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      // Push on the same edge as the final right-word pop.
      for (int k = 0; k < 40 && !(q.size() == 1 && on_right); k++) step(0, 1, 0);
      step(1, 1, 0);
      repeat (6) step(0, 1, 0);
      // Reset while mid-frame with five frames stored.
      repeat (10) step(0, 1, 0);
      repeat (5) step(1, 0, 0);
      step(0, 1, 0);
      step(0, 0, 1);
      repeat (6) step(1, 0, 0);
      repeat (200) step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 70, 0);
      step(0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
